// File: rtl/controle_jogo_timeout_pkg.sv
// controle_jogo_timeout_pkg: state codes shared with the hex decoder and the default play timeout.
package controle_jogo_timeout_pkg;
    localparam int TIMEOUT_CICLOS_PADRAO = 3000;
    typedef enum logic [3:0] {
        inicial        = 4'h0,
        preparacao     = 4'h1,
        inicio_rodada  = 4'h2,
        espera_jogada  = 4'h3,
        registra       = 4'h4,
        comparacao     = 4'h5,
        proxima_jogada = 4'h6,
        proxima_rodada = 4'h7,
        fim_acerto     = 4'hA,
        fim_timeout    = 4'hD,
        fim_erro       = 4'hE
    } estado_t;
endpackage

// File: rtl/controle_jogo_timeout_contador.sv
// contador_timeout: saturating play timer; fim flags the last allowed cycle of a wait.
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 3000,
    parameter int W_TIMEOUT = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_i,
    input  logic conta_i,
    output logic fim_o
);
    logic [W_TIMEOUT-1:0] cont_q, cont_d;
    assign fim_o = cont_q == W_TIMEOUT'(TIMEOUT_CICLOS - 1);
    always_comb cont_d = zera_i ? '0 : (conta_i && !fim_o) ? cont_q + 1'b1 : cont_q;
    always_ff @(posedge clock or posedge reset)
        if (reset) cont_q <= '0;
        else cont_q <= cont_d;
endmodule

// File: rtl/controle_jogo_timeout.sv
// controle_jogo_timeout: Moore control unit sequencing the memory-game datapath, with per-play timeout.
module controle_jogo_timeout
    import controle_jogo_timeout_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
    parameter int W_TIMEOUT = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       jogada_igual,
    input  logic       fim_rodada,
    input  logic       fim_jogo,
    output logic       zera_E,
    output logic       conta_E,
    output logic       zera_L,
    output logic       conta_L,
    output logic       zera_R,
    output logic       registra_R,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);
    estado_t estado_q, estado_d;
    logic fim_t;
    contador_timeout #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS), .W_TIMEOUT(W_TIMEOUT)) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .zera_i (estado_q != espera_jogada),
        .conta_i(estado_q == espera_jogada),
        .fim_o  (fim_t)
    );
    always_ff @(posedge clock or posedge reset)
        if (reset) estado_q <= inicial;
        else estado_q <= estado_d;
    // A play arriving on the terminal count takes priority over the timeout.
    always_comb begin
        estado_d = inicial;
        case (estado_q)
            inicial:        estado_d = iniciar ? preparacao : inicial;
            preparacao:     estado_d = inicio_rodada;
            inicio_rodada:  estado_d = espera_jogada;
            espera_jogada:  estado_d = jogada_feita ? registra : fim_t ? fim_timeout : espera_jogada;
            registra:       estado_d = comparacao;
            comparacao:     estado_d = !jogada_igual ? fim_erro : !fim_rodada ? proxima_jogada :
                                       !fim_jogo ? proxima_rodada : fim_acerto;
            proxima_jogada: estado_d = espera_jogada;
            proxima_rodada: estado_d = inicio_rodada;
            fim_acerto, fim_erro, fim_timeout: estado_d = iniciar ? preparacao : estado_q;
            default:        estado_d = inicial;
        endcase
    end
    assign zera_E     = estado_q == preparacao || estado_q == inicio_rodada;
    assign conta_E    = estado_q == proxima_jogada;
    assign zera_L     = estado_q == preparacao;
    assign conta_L    = estado_q == proxima_rodada;
    assign zera_R     = estado_q == preparacao;
    assign registra_R = estado_q == registra;
    assign acertou    = estado_q == fim_acerto;
    assign errou      = estado_q == fim_erro;
    assign timeout    = estado_q == fim_timeout;
    assign pronto     = acertou || errou || timeout;
    assign db_estado  = estado_q;
endmodule

// File: tb/tb_controle_jogo_timeout.sv
// tb_controle_jogo_timeout: directed plus randomized games checked against a round/address game model.
module tb_controle_jogo_timeout;
    localparam int T = 3000;
    localparam int LAST = 3;
    logic clock = 0, reset = 1, iniciar = 0, jogada_feita = 0;
    logic jogada_igual = 0, fim_rodada = 0, fim_jogo = 0;
    logic zera_E, conta_E, zera_L, conta_L, zera_R, registra_R;
    logic pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [9:0] outs;
    int tests = 0, fails = 0;
    int a = 0, r = 0;
    logic [3:0] ultimo;
    bit fim, ig;

    controle_jogo_timeout dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
        .jogada_igual(jogada_igual), .fim_rodada(fim_rodada), .fim_jogo(fim_jogo),
        .zera_E(zera_E), .conta_E(conta_E), .zera_L(zera_L), .conta_L(conta_L),
        .zera_R(zera_R), .registra_R(registra_R), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    assign outs = {zera_E, conta_E, zera_L, conta_L, zera_R, registra_R, pronto, acertou, errou, timeout};

    // Expected outputs per state: {zE,cE,zL,cL,zR,rR,pronto,acertou,errou,timeout}
    function automatic logic [9:0] out_exp(input logic [3:0] s);
        case (s)
            4'h1: return 10'b1010100000;
            4'h2: return 10'b1000000000;
            4'h4: return 10'b0000010000;
            4'h6: return 10'b0100000000;
            4'h7: return 10'b0001000000;
            4'hA: return 10'b0000001100;
            4'hE: return 10'b0000001010;
            4'hD: return 10'b0000001001;
            default: return 10'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] s);
        tests++;
        assert (db_estado === s) else begin
            fails++;
            $error("FAIL %s estado got=%0h exp=%0h", tag, db_estado, s);
        end
        tests++;
        assert (outs === out_exp(s)) else begin
            fails++;
            $error("FAIL %s saidas got=%b exp=%b", tag, outs, out_exp(s));
        end
    endtask

    task automatic wait3(input int w);
        for (int i = 0; i < w; i++) begin
            step();
            chk("espera", 4'h3);
        end
    endtask

    task automatic hold(input logic [3:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            jogada_feita = 1'($urandom_range(0, 1));
            step();
            chk("mantem", s);
        end
        jogada_feita = 0;
    endtask

    task automatic start();
        iniciar = 1;
        step();
        iniciar = 0;
        chk("preparacao", 4'h1);
        step();
        chk("inicio_rodada", 4'h2);
        step();
        chk("espera_inicial", 4'h3);
        a = 0;
        r = 0;
    endtask

    // One play: w idle cycles in the wait state, then a play judged by the game model.
    task automatic play(input int w, input bit igual);
        bit fr, fj;
        fr = (a == r);
        fj = (r == LAST);
        ultimo = 4'h0;
        wait3(w);
        jogada_feita = 1;
        jogada_igual = igual;
        fim_rodada = fr;
        fim_jogo = fj;
        step();
        jogada_feita = 0;
        chk("registra", 4'h4);
        step();
        chk("comparacao", 4'h5);
        step();
        if (!igual) begin
            chk("erro", 4'hE);
            ultimo = 4'hE;
        end else if (!fr) begin
            chk("prox_jogada", 4'h6);
            step();
            chk("volta_espera", 4'h3);
            a++;
        end else if (!fj) begin
            chk("prox_rodada", 4'h7);
            step();
            chk("nova_rodada", 4'h2);
            step();
            chk("espera_rodada", 4'h3);
            r++;
            a = 0;
        end else begin
            chk("acerto", 4'hA);
            ultimo = 4'hA;
        end
    endtask

    initial begin
        repeat (10) begin
            step();
            chk("reset", 4'h0);
        end
        @(negedge clock);
        reset = 0;
        hold(4'h0, 5);
        start();
        play(2, 1);
        play(3, 1);
        play(1, 0);
        hold(4'hE, 50);
        start();
        play(T - 1, 1);
        wait3(T - 1);
        step();
        chk("timeout", 4'hD);
        hold(4'hD, 5);
        start();
        fim = 0;
        while (!fim) begin
            fim = (a == r && r == LAST);
            play($urandom_range(0, 15), 1);
        end
        hold(4'hA, 5);
        start();
        repeat (3) begin
            fim = 0;
            while (!fim) begin
                ig = ($urandom_range(0, 7) != 0);
                fim = !ig || (a == r && r == LAST);
                play($urandom_range(0, 10), ig);
            end
            hold(ultimo, 3);
            start();
        end
        wait3(1499);
        #2 reset = 1;
        #1;
        chk("reset_async", 4'h0);
        @(negedge clock);
        reset = 0;
        hold(4'h0, 10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/controle_jogo_timeout.md
Name: controle_jogo_timeout

Overview:
- Control unit (Moore FSM) that sequences the memory-game datapath: address counter, round-limit counter, play register and comparator.
- Runs rounds of increasing length. Each round, the player repeats stored plays 0..limit.
- Ends the game on a wrong play, on a per-play timeout, or on completion of the last round.
- Sits beside the datapath inside the game top level. Datapath status bits come in; counter/register enables and game-status flags go out.

Parameters:
- TIMEOUT_CICLOS, 3000, clock cycles allowed per play in the wait state (3 s at 1 kHz).
- W_TIMEOUT, 12, width of the internal timeout counter; must satisfy 2^W_TIMEOUT >= TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  start/restart request, level-sampled.
- jogada_feita  in  1  one-cycle pulse from the datapath edge detector when a switch is pressed.
- jogada_igual  in  1  registered play equals memory word at current address.
- fim_rodada  in  1  address counter equals round limit.
- fim_jogo  in  1  round limit equals last memory address.
- zera_E  out  1  clear address counter.
- conta_E  out  1  increment address counter.
- zera_L  out  1  clear round-limit counter.
- conta_L  out  1  increment round-limit counter.
- zera_R  out  1  clear play register.
- registra_R  out  1  load play register from switches.
- pronto  out  1  game finished.
- acertou  out  1  game won.
- errou  out  1  wrong play.
- timeout  out  1  player took too long.
- db_estado  out  4  current state code, for the hex display.

Behaviour:
- Reset: asynchronous. State returns to inicial at once; timeout counter cleared; all outputs 0; db_estado=0. Reset mid-game abandons the game with no residue.
- All outputs decode from the current state only (Moore). Enables are high for exactly one cycle per state visit.
- States, with codes:
  - inicial(0): no outputs. iniciar=1 -> preparacao.
  - preparacao(1): zera_E, zera_L, zera_R. -> inicio_rodada.
  - inicio_rodada(2): zera_E. -> espera_jogada.
  - espera_jogada(3): timeout counter enabled.
    - jogada_feita=1 -> registra.
    - else, counter == TIMEOUT_CICLOS-1 -> fim_timeout.
    - else stay.
  - registra(4): registra_R. -> comparacao.
  - comparacao(5): decision on jogada_igual, fim_rodada, fim_jogo:
    - jogada_igual=0 -> fim_erro.
    - jogada_igual=1, fim_rodada=0 -> proxima_jogada.
    - jogada_igual=1, fim_rodada=1, fim_jogo=0 -> proxima_rodada.
    - jogada_igual=1, fim_rodada=1, fim_jogo=1 -> fim_acerto.
  - proxima_jogada(6): conta_E. -> espera_jogada.
  - proxima_rodada(7): conta_L. -> inicio_rodada.
  - fim_acerto(A): pronto=1, acertou=1.
  - fim_erro(E): pronto=1, errou=1.
  - fim_timeout(D): pronto=1, timeout=1.
- Final states are held until iniciar=1. iniciar=1 in any final state -> preparacao (restart). iniciar is ignored in all other states.
- Timeout counter behaviour:
  - Counts only in espera_jogada. Holds 0 in every other state, so each entry to espera_jogada starts from 0.
  - Saturates; it never wraps.
  - espera_jogada therefore lasts at most TIMEOUT_CICLOS cycles.
- Simultaneous events: jogada_feita and counter terminal in the same cycle -> the play wins (registra), no timeout.
- Latency:
  - jogada_feita at cycle t -> registra_R at t+1.
  - Comparison decision at t+2.
  - conta_E or conta_L, or the final state, at t+3.
- jogada_feita pulses outside espera_jogada are ignored.
- Unused codes (8, 9, B, C, F) -> inicial on the next clock.

Decomposition:
- Shared package holds:
  - 4-bit state encodings listed above, reused by the datapath hex decoder.
  - Default TIMEOUT_CICLOS.
- One sub-module, contador_timeout:
  - Parameterised saturating counter with zera and conta inputs.
  - Asserts fim when count == TIMEOUT_CICLOS-1.
- FSM state register, next-state logic and output decode stay in the top module.

Test Plan:
- Start-up: reset 10 cycles, then iniciar for 1 cycle -> db_estado 0,1,2,3. zera_E=zera_L=zera_R=1 only in state 1; zera_E=1 in state 2.
- Round 1 correct: jogada_feita pulse with jogada_igual=1, fim_rodada=1, fim_jogo=0 -> db_estado 4,5,7,2,3. conta_L=1 for exactly 1 cycle; no conta_E.
- Mid-round play: jogada_igual=1, fim_rodada=0 -> 4,5,6,3 with one conta_E pulse. Then jogada_igual=0 -> 4,5,E with errou=1, pronto=1 held for 50 cycles until iniciar -> state 1.
- Timeout boundary, TIMEOUT_CICLOS=3000:
  - Stay in state 3 for 2999 cycles, then pulse jogada_feita on the last cycle -> registra, no timeout.
  - Next wait with no play -> state D after exactly 3000 cycles in state 3, with timeout=1 and pronto=1.
  - iniciar -> restart, outputs cleared.
- Win: final round with fim_jogo=1 -> state A, acertou=1, pronto=1, errou=timeout=0.
- Async reset asserted at 1500 cycles into espera_jogada, between clock edges -> state 0 and all outputs 0 before the next edge. After release with no iniciar, stays in 0.
